// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the pipeline front end: default widths, the NOP
//   encoding (addi x0, x0, 0) and the instruction-fetch FSM state encoding.
//   No ports; imported by if_fetch and if_fetch_perf.
package pipeline_pkg;

  localparam int DEFAULT_WORD_BITWIDTH    = 32;
  localparam int DEFAULT_REG_NUM_BITWIDTH = 5;
  localparam int PERF_CNT_BITWIDTH        = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_perf.sv
// if_fetch_perf
//   Three free-running, wrapping event counters for the fetch stage.
//   Ports:
//     clk, rst            clock / asynchronous active-high reset
//     fetch_accept        an ack was accepted into ID or the hold buffer
//     stall               hazard stall active this cycle
//     redirect            branch redirect / flush this cycle
//     perf_fetched        count of accepted fetches
//     perf_stall_cycles   count of cycles with stall high
//     perf_flushes        count of redirects
//   Only instantiated when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_perf
  import pipeline_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_accept,
  input  logic                         stall,
  input  logic                         redirect,
  output logic [PERF_CNT_BITWIDTH-1:0] perf_fetched,
  output logic [PERF_CNT_BITWIDTH-1:0] perf_stall_cycles,
  output logic [PERF_CNT_BITWIDTH-1:0] perf_flushes
);

  logic [2:0]                   event_vec;
  logic [PERF_CNT_BITWIDTH-1:0] cnt_reg [3];

  assign event_vec = {redirect, stall, fetch_accept};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (event_vec[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + PERF_CNT_BITWIDTH'(1);
        end
      end
    end
  endgenerate

  assign perf_fetched      = cnt_reg[0];
  assign perf_stall_cycles = cnt_reg[1];
  assign perf_flushes      = cnt_reg[2];

endmodule

// File: rtl/if_fetch.sv
// if_fetch
//   Instruction-fetch stage plus IF/ID pipeline register. Keeps the PC, runs
//   a req/ack handshake to instruction memory and presents the fetched
//   instruction to decode. Handles hazard stalls (via a one-entry hold buffer),
//   branch redirects with flush, and draining of an in-flight fetch.
//   Ports:
//     clk, rst               clock / asynchronous active-high reset
//     stall                  ID must keep its contents
//     redirect, redirect_pc  new fetch target (low two bits ignored)
//     imem_req, imem_addr    fetch request / address (stable until ack)
//     imem_ack, imem_rdata   fetch completion / instruction word
//     id_pc, id_inst         IF/ID register contents (NOP when invalid)
//     id_valid               ID holds a real instruction
//     id_Rs1, id_Rs2         early source register fields of id_inst
//   Optional: IF_FETCH_PERF_CNT_EN adds perf_fetched, perf_stall_cycles,
//   perf_flushes counter outputs.
module if_fetch
  import pipeline_pkg::*;
#(
  parameter int                       WORD_BITWIDTH    = DEFAULT_WORD_BITWIDTH,
  parameter int                       REG_NUM_BITWIDTH = DEFAULT_REG_NUM_BITWIDTH,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        redirect,
  input  logic [WORD_BITWIDTH-1:0]    redirect_pc,
  output logic                        imem_req,
  output logic [WORD_BITWIDTH-1:0]    imem_addr,
  input  logic                        imem_ack,
  input  logic [WORD_BITWIDTH-1:0]    imem_rdata,
  output logic [WORD_BITWIDTH-1:0]    id_pc,
  output logic [WORD_BITWIDTH-1:0]    id_inst,
  output logic                        id_valid,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [PERF_CNT_BITWIDTH-1:0] perf_fetched,
  output logic [PERF_CNT_BITWIDTH-1:0] perf_stall_cycles,
  output logic [PERF_CNT_BITWIDTH-1:0] perf_flushes,
`endif
  output logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
  output logic [REG_NUM_BITWIDTH-1:0] id_Rs2
);

  localparam logic [WORD_BITWIDTH-1:0] NOP = WORD_BITWIDTH'(NOP_INST);

  fetch_state_e state_reg, state_next;

  logic [WORD_BITWIDTH-1:0] pc_reg, pc_next;
  logic [WORD_BITWIDTH-1:0] req_addr_reg, req_addr_next;
  logic [WORD_BITWIDTH-1:0] hold_inst_reg, hold_inst_next;
  logic [WORD_BITWIDTH-1:0] hold_pc_reg, hold_pc_next;
  logic [WORD_BITWIDTH-1:0] id_pc_reg, id_pc_next;
  logic [WORD_BITWIDTH-1:0] id_inst_reg, id_inst_next;
  logic                     id_valid_reg, id_valid_next;

  logic [WORD_BITWIDTH-1:0] redirect_target;
  logic [WORD_BITWIDTH-1:0] pc_plus4;
  logic                     req_outstanding;

  // Word-align the target by masking rather than slicing so every bit of
  // redirect_pc is consumed.
  assign redirect_target = redirect_pc & ~WORD_BITWIDTH'(3);
  assign pc_plus4        = pc_reg + WORD_BITWIDTH'(4);
  assign req_outstanding = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: begin
        if (redirect) begin
          // An unacknowledged request must still complete before refetching.
          state_next = imem_ack ? ST_FETCH : ST_DRAIN;
        end else if (imem_ack && stall) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD:  if (redirect || !stall) state_next = ST_FETCH;
      ST_DRAIN: if (imem_ack) state_next = ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    imem_req  = req_outstanding;
    imem_addr = req_addr_reg;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    pc_next        = pc_reg;
    req_addr_next  = req_addr_reg;
    hold_inst_next = hold_inst_reg;
    hold_pc_next   = hold_pc_reg;
    id_pc_next     = id_pc_reg;
    id_inst_next   = id_inst_reg;
    id_valid_next  = id_valid_reg;

    if (redirect) begin
      // Flush overrides stall: ID gets a bubble even if decode is stalled.
      id_inst_next   = NOP;
      id_valid_next  = 1'b0;
      hold_inst_next = NOP;
      hold_pc_next   = '0;
      pc_next        = redirect_target;
      // While a request is outstanding and unacked, imem_addr must not move;
      // DRAIN reloads req_addr from pc once the ack arrives.
      if (!req_outstanding || imem_ack) begin
        req_addr_next = redirect_target;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          req_addr_next = RESET_PC;
          if (!stall) begin
            id_inst_next  = NOP;
            id_valid_next = 1'b0;
          end
        end
        ST_FETCH: begin
          if (imem_ack && stall) begin
            hold_inst_next = imem_rdata;
            hold_pc_next   = pc_reg;
          end else if (imem_ack) begin
            id_pc_next    = pc_reg;
            id_inst_next  = imem_rdata;
            id_valid_next = 1'b1;
            pc_next       = pc_plus4;
            req_addr_next = pc_plus4;
          end else if (!stall) begin
            id_inst_next  = NOP;
            id_valid_next = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            id_pc_next    = hold_pc_reg;
            id_inst_next  = hold_inst_reg;
            id_valid_next = 1'b1;
            pc_next       = pc_plus4;
            req_addr_next = pc_plus4;
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            id_inst_next  = NOP;
            id_valid_next = 1'b0;
          end
          // Drained data is dropped; resume at the redirect target held in pc.
          if (imem_ack) begin
            req_addr_next = pc_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      req_addr_reg  <= RESET_PC;
      hold_inst_reg <= NOP;
      hold_pc_reg   <= '0;
      id_pc_reg     <= '0;
      id_inst_reg   <= NOP;
      id_valid_reg  <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      req_addr_reg  <= req_addr_next;
      hold_inst_reg <= hold_inst_next;
      hold_pc_reg   <= hold_pc_next;
      id_pc_reg     <= id_pc_next;
      id_inst_reg   <= id_inst_next;
      id_valid_reg  <= id_valid_next;
    end
  end

  assign id_pc    = id_pc_reg;
  assign id_inst  = id_inst_reg;
  assign id_valid = id_valid_reg;
  assign id_Rs1   = id_inst_reg[15 +: REG_NUM_BITWIDTH];
  assign id_Rs2   = id_inst_reg[20 +: REG_NUM_BITWIDTH];

`ifdef IF_FETCH_PERF_CNT_EN
  logic fetch_accept;

  assign fetch_accept = (state_reg == ST_FETCH) && imem_ack && !redirect;

  if_fetch_perf u_perf (
    .clk               (clk),
    .rst               (rst),
    .fetch_accept      (fetch_accept),
    .stall             (stall),
    .redirect          (redirect),
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
  );
`endif

endmodule
